// File: rtl/instr_stream_encoder_if.sv
// instr_stream_encoder_if: field-level instruction request bus between a producer and the encoder
interface instr_stream_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rn;
  logic [3:0]  rd;
  logic [11:0] src2;
  logic        finish;
  modport master (output req_valid, cond, op, funct, rn, rd, src2, finish, input req_ready);
  modport slave (input req_valid, cond, op, funct, rn, rd, src2, finish, output req_ready);
endinterface

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: checks and packs instruction requests into ARM words and loads them into instruction memory
module instr_stream_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_stream_encoder_if.slave req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [ADDR_W:0]      word_count,
  output logic                 err,
  output logic [7:0]           err_count,
  output logic                 full,
  output logic                 cpu_hold
);
  localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       TERM_WORD = 32'hEAFFFFFE;
  typedef enum logic [1:0] {LOAD, TERM, DONE} state_t;
  state_t              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                err_q, err_d;
  logic [7:0]          err_count_q, err_count_d;
  logic [3:0]          alu_cmd;
  logic                legal, xfer, wr_req, wr_term;
  logic [31:0]         req_word;
  // Legality of the presented request and its packed instruction word
  always_comb begin
    alu_cmd  = req.funct[4:1];
    legal    = req.cond != 4'hF && (
               req.op == 2'b00 ? (alu_cmd inside {4'b0000, 4'b0010, 4'b0100, 4'b1100, 4'b1101} ||
                                  (alu_cmd == 4'b1010 && req.funct[0])) :
               req.op == 2'b01 ? !req.funct[2] :
               req.op == 2'b10 ? req.funct[5:4] == 2'b10 : 1'b0);
    req_word = {req.cond, req.op, req.funct, req.rn, req.rd, req.src2};
  end
  // Next state: finish ends loading, the terminator slot always lasts one cycle
  always_comb state_d = state_q == LOAD ? (req.finish ? TERM : LOAD) : DONE;
  // Handshake, status and registered write-port outputs
  always_comb begin
    full          = word_count_q == DEPTH;
    req.req_ready = state_q == LOAD && !full && !reset;
    cpu_hold      = state_q != DONE;
    mem_we        = mem_we_q;
    mem_addr      = mem_addr_q;
    mem_wdata     = mem_wdata_q;
    word_count    = word_count_q;
    err           = err_q;
    err_count     = err_count_q;
  end
  // Write port and counters; the terminator is only written while capacity remains
  always_comb begin
    xfer         = req.req_valid && req.req_ready;
    wr_req       = xfer && legal;
    wr_term      = state_q == TERM && !full;
    mem_we_d     = wr_req || wr_term;
    mem_addr_d   = mem_we_d ? BASE + word_count_q[ADDR_W-1:0] : mem_addr_q;
    mem_wdata_d  = wr_term ? TERM_WORD : wr_req ? req_word : mem_wdata_q;
    word_count_d = word_count_q + (ADDR_W+1)'(mem_we_d);
    err_d        = xfer && !legal;
    err_count_d  = err_count_q + 8'(err_d && err_count_q != 8'hFF);
  end
  // State register
  always_ff @(posedge clk)
    if (reset) state_q <= LOAD;
    else state_q <= state_d;
  // Datapath registers; reset drops any pending write
  always_ff @(posedge clk)
    if (reset) begin
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE;
      mem_wdata_q  <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
    end
endmodule

// File: tb/tb_instr_stream_encoder.sv
// tb_instr_stream_encoder: random and directed stimulus on a 64-word and a 4-word encoder against a reference model
module tb_instr_stream_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, v, fin;
  logic [3:0] c, n, d;
  logic [1:0] o;
  logic [5:0] f;
  logic [11:0] s;
  instr_stream_encoder_if bus0();
  instr_stream_encoder_if bus1();
  assign bus0.req_valid = v;
  assign bus0.cond = c;
  assign bus0.op = o;
  assign bus0.funct = f;
  assign bus0.rn = n;
  assign bus0.rd = d;
  assign bus0.src2 = s;
  assign bus0.finish = fin;
  assign bus1.req_valid = v;
  assign bus1.cond = c;
  assign bus1.op = o;
  assign bus1.funct = f;
  assign bus1.rn = n;
  assign bus1.rd = d;
  assign bus1.src2 = s;
  assign bus1.finish = fin;
  logic we_o[2], err_o[2], full_o[2], hold_o[2], rdy_o[2];
  logic [5:0] addr_o[2];
  logic [6:0] wc_o[2];
  logic [7:0] ec_o[2];
  logic [31:0] wd_o[2];
  logic [1:0] addr_s;
  logic [2:0] wc_s;
  assign rdy_o[0] = bus0.req_ready;
  assign rdy_o[1] = bus1.req_ready;
  assign addr_o[1] = {4'b0, addr_s};
  assign wc_o[1] = {4'b0, wc_s};
  instr_stream_encoder dut0 (
    .clk(clk), .reset(rst), .req(bus0), .mem_we(we_o[0]), .mem_addr(addr_o[0]), .mem_wdata(wd_o[0]),
    .word_count(wc_o[0]), .err(err_o[0]), .err_count(ec_o[0]), .full(full_o[0]), .cpu_hold(hold_o[0])
  );
  instr_stream_encoder #(.ADDR_W(2)) dut1 (
    .clk(clk), .reset(rst), .req(bus1), .mem_we(we_o[1]), .mem_addr(addr_s), .mem_wdata(wd_o[1]),
    .word_count(wc_s), .err(err_o[1]), .err_count(ec_o[1]), .full(full_o[1]), .cpu_hold(hold_o[1])
  );
  int n_chk = 0, n_fail = 0;
  int depth[2] = '{64, 4};
  int m_st[2], m_cnt[2], m_ecnt[2], m_addr[2];
  bit m_we[2], m_err[2], m_rst[2];
  logic [31:0] m_wd[2];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit legal_ref(input logic [3:0] cc, input logic [1:0] oo, input logic [5:0] ff);
    int cmd = (int'(ff) >> 1) % 16;
    if (cc == 4'hF || oo == 2'b11) return 1'b0;
    if (oo == 2'b01) return (int'(ff) / 4) % 2 == 0;
    if (oo == 2'b10) return int'(ff) / 16 == 2;
    return cmd == 0 || cmd == 2 || cmd == 4 || cmd == 12 || cmd == 13 || (cmd == 10 && int'(ff) % 2 == 1);
  endfunction
  function automatic logic [31:0] pack(input logic [3:0] cc, input logic [1:0] oo, input logic [5:0] ff,
                                       input logic [3:0] nn, input logic [3:0] dd, input logic [11:0] ss);
    return (32'(cc) << 28) | (32'(oo) << 26) | (32'(ff) << 20) | (32'(nn) << 16) | (32'(dd) << 12) | 32'(ss);
  endfunction
  task automatic model_step(input int k);
    int nxt;
    m_rst[k] = rst;
    m_we[k] = 1'b0;
    m_err[k] = 1'b0;
    if (rst) begin
      m_st[k] = 0;
      m_cnt[k] = 0;
      m_ecnt[k] = 0;
    end else begin
      nxt = m_st[k] == 0 ? (fin ? 1 : 0) : 2;
      if (m_st[k] == 0 && v && m_cnt[k] < depth[k]) begin
        if (legal_ref(c, o, f)) begin
          m_we[k] = 1'b1;
          m_addr[k] = m_cnt[k];
          m_wd[k] = pack(c, o, f, n, d, s);
          m_cnt[k]++;
        end else begin
          m_err[k] = 1'b1;
          if (m_ecnt[k] < 255) m_ecnt[k]++;
        end
      end else if (m_st[k] == 1 && m_cnt[k] < depth[k]) begin
        m_we[k] = 1'b1;
        m_addr[k] = m_cnt[k];
        m_wd[k] = 32'hEAFFFFFE;
        m_cnt[k]++;
      end
      m_st[k] = nxt;
    end
  endtask
  task automatic cyc(input bit r, input bit vv, input bit fn, input logic [3:0] cc, input logic [1:0] oo,
                     input logic [5:0] fu, input logic [3:0] nn, input logic [3:0] dd, input logic [11:0] ss);
    rst = r; v = vv; fin = fn; c = cc; o = oo; f = fu; n = nn; d = dd; s = ss;
    #1;
    for (int k = 0; k < 2; k++)
      check($sformatf("ready%0d", k), rdy_o[k], !r && m_st[k] == 0 && m_cnt[k] < depth[k]);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mem_we%0d", k), we_o[k], m_we[k]);
      check($sformatf("err%0d", k), err_o[k], m_err[k]);
      check($sformatf("err_count%0d", k), ec_o[k], m_ecnt[k]);
      check($sformatf("word_count%0d", k), wc_o[k], m_cnt[k]);
      check($sformatf("full%0d", k), full_o[k], m_cnt[k] == depth[k]);
      check($sformatf("cpu_hold%0d", k), hold_o[k], m_st[k] != 2);
      if (m_we[k]) begin
        check($sformatf("mem_addr%0d", k), addr_o[k], m_addr[k]);
        check($sformatf("mem_wdata%0d", k), wd_o[k], m_wd[k]);
      end
      if (m_rst[k]) begin
        check($sformatf("rst_addr%0d", k), addr_o[k], 0);
        check($sformatf("rst_wdata%0d", k), wd_o[k], 0);
      end
    end
  endtask
  task automatic idle(input bit r, input bit fn);
    cyc(r, 1'b0, fn, 4'h0, 2'b00, 6'h0, 4'h0, 4'h0, 12'h0);
  endtask
  task automatic rand_req(input int pv, input int pl, input bit fn, input bit bad);
    logic [3:0] cc, nn, dd;
    logic [1:0] oo;
    logic [5:0] fu;
    logic [11:0] ss;
    int cmds[6] = '{0, 2, 4, 10, 12, 13};
    int kind, cm;
    cc = 4'($urandom); oo = 2'($urandom); fu = 6'($urandom);
    nn = 4'($urandom); dd = 4'($urandom); ss = 12'($urandom);
    if ($urandom_range(0, 99) < pl) begin
      cc = 4'($urandom_range(0, 14));
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        cm = cmds[$urandom_range(0, 5)];
        oo = 2'b00;
        fu = {fu[5], 4'(cm), cm == 10 ? 1'b1 : fu[0]};
      end else if (kind == 1) begin
        oo = 2'b01;
        fu[2] = 1'b0;
      end else begin
        oo = 2'b10;
        fu[5:4] = 2'b10;
      end
    end
    if (bad) cc = 4'hF;
    cyc(1'b0, $urandom_range(0, 99) < pv, fn, cc, oo, fu, nn, dd, ss);
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_ecnt[k] = 0; m_addr[k] = 0; m_wd[k] = 0;
    end
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005);
    check("add_word", wd_o[0], 32'hE2821005);
    check("add_addr", addr_o[0], 0);
    check("add_count", wc_o[0], 1);
    cyc(1'b0, 1'b1, 1'b0, 4'hE, 2'b01, 6'b011001, 4'd0, 4'd3, 12'h004);
    check("ldr_word", wd_o[0], 32'hE5903004);
    check("ldr_addr", addr_o[0], 1);
    cyc(1'b0, 1'b1, 1'b0, 4'hE, 2'b10, 6'b100000, 4'd0, 4'd0, 12'h002);
    check("b_word", wd_o[0], 32'hEA000002);
    check("b_addr", addr_o[0], 2);
    cyc(1'b0, 1'b1, 1'b0, 4'hE, 2'b11, 6'b000000, 4'd1, 4'd1, 12'h001);
    cyc(1'b0, 1'b1, 1'b0, 4'hF, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005);
    cyc(1'b0, 1'b1, 1'b0, 4'hE, 2'b10, 6'b110000, 4'd0, 4'd0, 12'h002);
    check("illegal_err_count", ec_o[0], 3);
    check("illegal_word_count", wc_o[0], 3);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    check("term_word", wd_o[0], 32'hEAFFFFFE);
    check("term_addr", addr_o[0], 3);
    check("term_count", wc_o[0], 4);
    check("term_hold", hold_o[0], 0);
    cyc(1'b0, 1'b1, 1'b0, 4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005);
    check("done_ignores", wc_o[0], 4);
    for (int ep = 0; ep < 10; ep++) begin
      idle(1'b1, 1'b0);
      if (ep == 0) for (int i = 0; i < 70; i++) rand_req(100, 100, 1'b0, 1'b0);
      else if (ep == 1) begin
        for (int i = 0; i < 270; i++) rand_req(100, 0, 1'b0, 1'b1);
        check("err_saturate", ec_o[0], 255);
      end else for (int i = 0, len = $urandom_range(2, 60); i < len; i++) rand_req(70, 50, 1'b0, 1'b0);
      rand_req(100, 100, 1'b1, 1'b0);
      if (ep % 2 == 1) idle(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) rand_req(50, 50, 1'($urandom), 1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
